// File: rtl/bcd_adder_4d_pkg.sv
// Shared constants and types for the packed-BCD adder.
package bcd_adder_4d_pkg;

    localparam int BCD_DIGIT_W   = 4;
    localparam int BCD_MAX_DIGIT = 9;
    localparam int BCD_CORR      = 6;

    typedef logic [3:0][BCD_DIGIT_W-1:0] bcd_word_t;

endpackage

// File: rtl/bcd_digit_add.sv
// Single BCD digit adder: binary sum with +6 decimal correction.
module bcd_digit_add
    import bcd_adder_4d_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] a,
    input  logic [BCD_DIGIT_W-1:0] b,
    input  logic                   ci,
    output logic [BCD_DIGIT_W-1:0] digit,
    output logic                   co
);

    logic [BCD_DIGIT_W:0] s;
    logic [BCD_DIGIT_W:0] s_corr;

    always_comb begin
        s      = {1'b0, a} + {1'b0, b} + {{BCD_DIGIT_W{1'b0}}, ci};
        s_corr = s + (BCD_DIGIT_W+1)'(BCD_CORR);
        co     = (s > (BCD_DIGIT_W+1)'(BCD_MAX_DIGIT));
        digit  = co ? s_corr[BCD_DIGIT_W-1:0] : s[BCD_DIGIT_W-1:0];
    end

endmodule

// File: rtl/bcd_adder_4d.sv
// Ripple packed-BCD adder, c = (a + b) mod 10^DIGITS, registered output.
// Define BCD_ADDER_CHECK_EN to add the err output flagging non-BCD operands.
module bcd_adder_4d
    import bcd_adder_4d_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] a,
    input  logic [BCD_DIGIT_W*DIGITS-1:0] b,
    output logic [BCD_DIGIT_W*DIGITS-1:0] c,
    output logic                          cout,
`ifdef BCD_ADDER_CHECK_EN
    output logic                          err,
`endif
    output logic                          out_valid
);

    localparam int W = BCD_DIGIT_W * DIGITS;

    logic [DIGITS:0] carry;
    logic [W-1:0]    sum;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_add u_digit (
            .a     (a[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .b     (b[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .ci    (carry[i]),
            .digit (sum[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .co    (carry[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c         <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                c    <= sum;
                cout <= carry[DIGITS];
            end
        end
    end

`ifdef BCD_ADDER_CHECK_EN
    logic bad;

    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX_DIGIT) ||
                b[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_DIGIT_W'(BCD_MAX_DIGIT))
                bad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else if (in_valid)
            err <= bad;
    end
`endif

endmodule

// File: tb/tb_bcd_adder_4d.sv
// Directed-vector bench for bcd_adder_4d.
module tb_bcd_adder_4d;
    import bcd_adder_4d_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    logic      in_valid;
    bcd_word_t a;
    bcd_word_t b;
    logic [15:0] c;
    logic      cout;
    logic      out_valid;
`ifdef BCD_ADDER_CHECK_EN
    logic      err;
`endif

    int checks = 0;
    int errors = 0;

    bcd_adder_4d #(.DIGITS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c         (c),
        .cout      (cout),
`ifdef BCD_ADDER_CHECK_EN
        .err       (err),
`endif
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic add(input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] ec, input logic ecout,
                       input string tag);
        a = x;
        b = y;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_c"}, 32'(c), 32'(ec));
        chk({tag, "_cout"}, 32'(cout), 32'(ecout));
        chk({tag, "_ov"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 16'($urandom);
        b        = 16'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_c", 32'(c), 32'h0);
        chk("rst_cout", 32'(cout), 32'h0);
        chk("rst_ov", 32'(out_valid), 32'h0);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        add(16'h1234, 16'h2918, 16'h4152, 1'b0, "chain");
        add(16'h9999, 16'h0001, 16'h0000, 1'b1, "ripple");
        add(16'h0001, 16'h7999, 16'h8000, 1'b0, "ripple2");
        add(16'h000A, 16'h000F, 16'h001F, 1'b0, "nonbcd");
        add(16'h1234, 16'h4321, 16'h5555, 1'b0, "nocorr");

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_c", 32'(c), 32'h5555);
            chk("hold_ov", 32'(out_valid), 32'h0);
        end

        a = 16'h9999;
        b = 16'h9999;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("b2b0_c", 32'(c), 32'h9998);
        chk("b2b0_cout", 32'(cout), 32'h1);
        chk("b2b0_ov", 32'(out_valid), 32'h1);
        a = 16'h5000;
        b = 16'h5000;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("b2b1_c", 32'(c), 32'h0000);
        chk("b2b1_cout", 32'(cout), 32'h1);
        chk("b2b1_ov", 32'(out_valid), 32'h1);

`ifdef BCD_ADDER_CHECK_EN
        add(16'h12A4, 16'h0001, 16'h1305, 1'b0, "chk_bad");
        chk("chk_bad_err", 32'(err), 32'h1);
        add(16'h0505, 16'h0505, 16'h1010, 1'b0, "chk_ok");
        chk("chk_ok_err", 32'(err), 32'h0);
`endif

        // async reset between edges, right after a result loads
        a = 16'h1234;
        b = 16'h2918;
        in_valid = 1'b1;
        @(posedge clk);
        #2;
        chk("pre_arst_c", 32'(c), 32'h4152);
        rst_n = 1'b0;
        #1;
        chk("arst_c", 32'(c), 32'h0);
        chk("arst_ov", 32'(out_valid), 32'h0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_ov", 32'(out_valid), 32'h0);
        chk("post_rst_c", 32'(c), 32'h0);
        add(16'h0505, 16'h0505, 16'h1010, 1'b0, "fresh");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_adder_4d.md
Name: bcd_adder_4d

Overview:
- Four-digit packed-BCD adder: c = (a + b) mod 10000, with decimal carry-out.
- Used by the game score/counter datapath, e.g. adding points to a displayed decimal score that drives 7-segment digits.
- Ripple of four single-digit BCD adders feeding a registered output stage.

Parameters:
- DIGITS, 4, number of BCD digits. Operand width is 4*DIGITS. Only 4 is required to be verified.

Ports:
- clk  input  1  system clock; rising edge active.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands a/b are sampled on this cycle.
- a  input  16  addend; packed BCD, digit 3 in [15:12] down to digit 0 in [3:0].
- b  input  16  addend; packed BCD, same layout.
- c  output  16  registered BCD sum, low four digits.
- cout  output  1  registered decimal carry out of digit 3 (sum >= 10000).
- out_valid  output  1  c/cout updated this cycle.

Behaviour:
- Reset: rst_n low asynchronously clears c=16'h0000, cout=0 and out_valid=0, regardless of clk. Release is synchronous to the next rising edge.
- Digit cell, for digits i = 0..3:
  - Compute s = a_i + b_i + ci, a 5-bit binary value.
  - If s > 9: digit = s + 6 (low 4 bits) and co = 1. Otherwise: digit = s and co = 0.
  - c0 = 0 for digit 0.
  - co of digit i feeds ci of digit i+1.
- Latency: 1 cycle.
  - On a rising edge with in_valid=1: c and cout load the combinational result, and out_valid=1 the following cycle.
  - On a rising edge with in_valid=0: c and cout hold their previous value, and out_valid=0.
- No back-pressure: a new operand pair is accepted every cycle. Back-to-back in_valid gives back-to-back out_valid.
- Wrap-around: the sum is taken modulo 10000.
  - 9999+0001 -> c=0000, cout=1.
  - 9999+9999 -> c=9998, cout=1 (maximum digit sum 19).
- Non-BCD input digits (A-F): no correction beyond the rule above. The result is defined by that rule but carries no decimal meaning.
- Reset asserted mid-stream: the pending result is discarded and out_valid is forced low. The first post-reset result requires a fresh in_valid.

Optional Feature:
- Macro BCD_ADDER_CHECK_EN.
- When defined:
  - Adds output err (1 bit, registered alongside c, reset 0).
  - err=1 if any nibble of a or b sampled with in_valid exceeds 9. Otherwise err=0.
  - c/cout are still computed per the digit rule.
- When undefined: no err port and no checking logic. All other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - BCD_DIGIT_W = 4.
  - BCD_MAX_DIGIT = 9.
  - BCD_CORR = 6.
  - A packed typedef for a 4-digit BCD word.
- One natural sub-module: bcd_digit_add (4-bit a, b, carry-in -> 4-bit digit, carry-out), purely combinational. It is instantiated DIGITS times with a generate loop.
- The top level holds only the carry chain, output registers and the optional checker.

Test Plan:
- Reset: hold rst_n=0 with random a/b and in_valid=1 -> c=0000, cout=0, out_valid=0. Asserting rst_n between edges clears the outputs immediately.
- a=1234, b=2918, in_valid=1 -> next cycle c=4152, cout=0, out_valid=1. This exercises digit carry chaining 4+8 and 3+1+1.
- a=9999, b=0001 -> c=0000, cout=1 (full ripple carry). Then a=0001, b=7999 -> c=8000, cout=0.
- a=1234, b=4321 -> c=5555, cout=0 (no correction). Then in_valid=0 for 3 cycles -> c stays 5555 and out_valid=0.
- Back-to-back:
  - Apply 9999+9999 then 5000+5000 on consecutive cycles -> c=9998/cout=1, then c=0000/cout=1, each exactly 1 cycle later.
- With BCD_ADDER_CHECK_EN defined:
  - a=12A4, b=0001 -> err=1.
  - a=0505, b=0505 -> c=1010, err=0.
